sprite_blitter: RTL and testbench

//   Parametrised sprite rasteriser: latches an SPR_W x SPR_H sprite (BPP bits/pixel) and a colour palette
//   on a start pulse, then emits one framebuffer write per accepted pixel, in row-major order.

---
 rtl/sprite_pkg.sv | 14 +
 rtl/sprite_pixel_mux.sv | 35 +++
 rtl/sprite_blitter.sv | 160 ++++++++++++++++
 tb/tb_sprite_blitter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite blitter slice.
package sprite_pkg;

  localparam int unsigned COORD_W   = 10;
  localparam int unsigned DEF_SCR_W = 640;
  localparam int unsigned DEF_SCR_H = 480;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } blit_state_t;

endpackage

// File: rtl/sprite_pixel_mux.sv
// Combinational sprite pixel fetch: (optionally mirrored) col/row -> palette index and colour.
module sprite_pixel_mux
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W   = 16,
  parameter int unsigned SPR_H   = 16,
  parameter int unsigned BPP     = 1,
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned COL_W   = 4,
  parameter int unsigned ROW_W   = 4
) (
  input  logic [SPR_W*SPR_H*BPP-1:0]   i_sprite,
  input  logic [(2**BPP)*COLOR_W-1:0]  i_palette,
  input  logic [COL_W-1:0]             i_col,
  input  logic [ROW_W-1:0]             i_row,
  input  logic                         i_flip_h,
  input  logic                         i_flip_v,
  output logic [BPP-1:0]               o_idx_c,
  output logic [COLOR_W-1:0]           o_color_c
);

  logic [COL_W-1:0] w_src_col;
  logic [ROW_W-1:0] w_src_row;
  logic [31:0]      w_pix;

  // Mirroring only changes which source pixel is read, never where it lands.
  always_comb begin
    w_src_col = i_flip_h ? (COL_W'(SPR_W - 1) - i_col) : i_col;
    w_src_row = i_flip_v ? (ROW_W'(SPR_H - 1) - i_row) : i_row;
    w_pix     = 32'(w_src_row) * 32'(SPR_W) + 32'(w_src_col);
    o_idx_c   = i_sprite[w_pix * BPP +: BPP];
    o_color_c = i_palette[32'(o_idx_c) * COLOR_W +: COLOR_W];
  end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite rasteriser: latches sprite/palette on start, emits one framebuffer write slot per pixel.
// Optional mirroring via SPRITE_BLIT_FLIP_EN (adds flip_h / flip_v inputs).
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W   = 16,
  parameter int unsigned SPR_H   = 16,
  parameter int unsigned BPP     = 1,
  parameter int unsigned COLOR_W = 8,
  parameter int unsigned SCR_W   = DEF_SCR_W,
  parameter int unsigned SCR_H   = DEF_SCR_H
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  input  logic [SPR_W*SPR_H*BPP-1:0]   sprite,
  input  logic [(2**BPP)*COLOR_W-1:0]  palette,
`ifdef SPRITE_BLIT_FLIP_EN
  input  logic                         flip_h,
  input  logic                         flip_v,
`endif
  input  logic                         wr_ready,
  output logic                         wr_en,
  output logic [COORD_W-1:0]           wr_x,
  output logic [COORD_W-1:0]           wr_y,
  output logic [COLOR_W-1:0]           wr_data,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned COL_W    = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int unsigned ROW_W    = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int unsigned SUM_W    = COORD_W + 1;
  localparam int unsigned SPR_BITS = SPR_W * SPR_H * BPP;
  localparam int unsigned PAL_BITS = (2**BPP) * COLOR_W;

  blit_state_t          r_state;
  logic [COORD_W-1:0]   r_x;
  logic [COORD_W-1:0]   r_y;
  logic [SPR_BITS-1:0]  r_sprite;
  logic [PAL_BITS-1:0]  r_palette;
  logic                 r_flip_h;
  logic                 r_flip_v;
  logic [COL_W-1:0]     r_col;
  logic [ROW_W-1:0]     r_row;
  logic                 r_last_out;

  logic                 w_flip_h_in;
  logic                 w_flip_v_in;
  logic [BPP-1:0]       w_idx;
  logic [COLOR_W-1:0]   w_color;
  logic [SUM_W-1:0]     w_sum_x;
  logic [SUM_W-1:0]     w_sum_y;
  logic                 w_write;
  logic                 w_col_last;
  logic                 w_pix_last;
  logic                 w_advance;

`ifdef SPRITE_BLIT_FLIP_EN
  assign w_flip_h_in = flip_h;
  assign w_flip_v_in = flip_v;
`else
  assign w_flip_h_in = 1'b0;
  assign w_flip_v_in = 1'b0;
`endif

  sprite_pixel_mux #(
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H),
    .BPP     (BPP),
    .COLOR_W (COLOR_W),
    .COL_W   (COL_W),
    .ROW_W   (ROW_W)
  ) u_pixel_mux (
    .i_sprite  (r_sprite),
    .i_palette (r_palette),
    .i_col     (r_col),
    .i_row     (r_row),
    .i_flip_h  (r_flip_h),
    .i_flip_v  (r_flip_v),
    .o_idx_c   (w_idx),
    .o_color_c (w_color)
  );

  // 11-bit sums so off-screen positions clip instead of wrapping onto the screen.
  assign w_sum_x    = SUM_W'(r_x) + SUM_W'(r_col);
  assign w_sum_y    = SUM_W'(r_y) + SUM_W'(r_row);
  assign w_write    = (w_idx != '0) && (w_sum_x < SUM_W'(SCR_W)) && (w_sum_y < SUM_W'(SCR_H));
  assign w_col_last = (r_col == COL_W'(SPR_W - 1));
  assign w_pix_last = w_col_last && (r_row == ROW_W'(SPR_H - 1));
  assign w_advance  = !wr_en || wr_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_sprite   <= '0;
      r_palette  <= '0;
      r_flip_h   <= 1'b0;
      r_flip_v   <= 1'b0;
      r_col      <= '0;
      r_row      <= '0;
      r_last_out <= 1'b0;
      wr_en      <= 1'b0;
      wr_x       <= '0;
      wr_y       <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_x        <= x;
            r_y        <= y;
            r_sprite   <= sprite;
            r_palette  <= palette;
            r_flip_h   <= w_flip_h_in;
            r_flip_v   <= w_flip_v_in;
            r_col      <= '0;
            r_row      <= '0;
            r_last_out <= 1'b0;
            busy       <= 1'b1;
            r_state    <= RUN;
          end
        end
        RUN: begin
          // r_last_out marks that the slot now on the outputs is the final pixel.
          if (w_advance) begin
            if (r_last_out) begin
              wr_en   <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              wr_en      <= w_write;
              wr_x       <= w_sum_x[COORD_W-1:0];
              wr_y       <= w_sum_y[COORD_W-1:0];
              wr_data    <= w_color;
              r_last_out <= w_pix_last;
              if (w_col_last) begin
                r_col <= '0;
                r_row <= w_pix_last ? '0 : (r_row + ROW_W'(1));
              end else begin
                r_col <= r_col + COL_W'(1);
              end
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Self-checking bench for sprite_blitter (BPP=2 instance) against a per-pixel reference model.
module tb_sprite_blitter;

  localparam int unsigned SPR_W   = 16;
  localparam int unsigned SPR_H   = 16;
  localparam int unsigned BPP     = 2;
  localparam int unsigned COLOR_W = 8;
  localparam int unsigned NPIX    = SPR_W * SPR_H;
  localparam int unsigned NPAL    = 2**BPP;
  localparam int unsigned SCR_W   = 640;
  localparam int unsigned SCR_H   = 480;

  logic                        clock = 1'b0;
  logic                        reset = 1'b0;
  logic                        start = 1'b0;
  logic [9:0]                  x = '0;
  logic [9:0]                  y = '0;
  logic [NPIX*BPP-1:0]         sprite = '0;
  logic [NPAL*COLOR_W-1:0]     palette = '0;
  logic                        wr_ready = 1'b1;
  logic                        wr_en;
  logic [9:0]                  wr_x;
  logic [9:0]                  wr_y;
  logic [COLOR_W-1:0]          wr_data;
  logic                        busy;
  logic                        done;
`ifdef SPRITE_BLIT_FLIP_EN
  logic                        flip_h = 1'b0;
  logic                        flip_v = 1'b0;
`endif

  sprite_blitter #(
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H),
    .BPP     (BPP),
    .COLOR_W (COLOR_W),
    .SCR_W   (SCR_W),
    .SCR_H   (SCR_H)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .y        (y),
    .sprite   (sprite),
    .palette  (palette),
`ifdef SPRITE_BLIT_FLIP_EN
    .flip_h   (flip_h),
    .flip_v   (flip_v),
`endif
    .wr_ready (wr_ready),
    .wr_en    (wr_en),
    .wr_x     (wr_x),
    .wr_y     (wr_y),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Scene description
  int unsigned pix [NPIX];
  logic [7:0]  pal [NPAL];
  int unsigned sx, sy;
  bit          fh, fv;

  // Reference model output: one slot per pixel in row-major order
  bit          exp_en [NPIX];
  logic [9:0]  exp_x  [NPIX];
  logic [9:0]  exp_y  [NPIX];
  logic [7:0]  exp_d  [NPIX];
  int          exp_writes;

  int          obs_writes;
  logic [9:0]  first_x, first_y, last_x, last_y;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build_model();
    exp_writes = 0;
    for (int r = 0; r < int'(SPR_H); r++) begin
      for (int c = 0; c < int'(SPR_W); c++) begin
        int p, scol, srow, ax, ay;
        int unsigned idx;
        p    = r * SPR_W + c;
        scol = fh ? (SPR_W - 1 - c) : c;
        srow = fv ? (SPR_H - 1 - r) : r;
        idx  = pix[srow * SPR_W + scol];
        ax   = int'(sx) + c;
        ay   = int'(sy) + r;
        exp_en[p] = (idx != 0) && (ax < int'(SCR_W)) && (ay < int'(SCR_H));
        exp_x[p]  = 10'(ax);
        exp_y[p]  = 10'(ay);
        exp_d[p]  = pal[idx];
        if (exp_en[p]) exp_writes++;
      end
    end
  endtask

  // mode 0: always ready; 1: random back-pressure; 2: 3-cycle stall on pixel 5
  task automatic run_blit(input int mode, input int abort_at, input bit poke);
    int k, cyc, stall_left;
    build_model();
    @(negedge clock);
    x = 10'(sx);
    y = 10'(sy);
    for (int p = 0; p < int'(NPIX); p++) sprite[p*BPP +: BPP] = BPP'(pix[p]);
    for (int i = 0; i < int'(NPAL); i++) palette[i*COLOR_W +: COLOR_W] = pal[i];
`ifdef SPRITE_BLIT_FLIP_EN
    flip_h = fh;
    flip_v = fv;
`endif
    wr_ready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("no_write_before_pixel0", wr_en, 0);
    k = 0; cyc = 0; stall_left = 3; obs_writes = 0;
    while (k < int'(NPIX)) begin
      @(negedge clock);
      cyc++;
      start = 1'b0;
      check("busy_run", busy, 1);
      check("done_run", done, 0);
      check("wr_en", wr_en, exp_en[k]);
      if (exp_en[k]) begin
        check("wr_x", wr_x, exp_x[k]);
        check("wr_y", wr_y, exp_y[k]);
        check("wr_data", wr_data, exp_d[k]);
      end
      if (k == abort_at) begin
        reset = 1'b0;
        @(negedge clock);
        check("abort_wr_en", wr_en, 0);
        check("abort_wr_x", wr_x, 0);
        check("abort_wr_y", wr_y, 0);
        check("abort_wr_data", wr_data, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_idle_busy", busy, 0);
        check("abort_idle_wr_en", wr_en, 0);
        return;
      end
      if (poke && cyc == 10) begin
        start = 1'b1;
        x = 10'(sx ^ 32'h155);
      end
      case (mode)
        1: wr_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (k == 5 && stall_left > 0) begin
            wr_ready = 1'b0;
            stall_left--;
          end else begin
            wr_ready = 1'b1;
          end
        end
        default: wr_ready = 1'b1;
      endcase
      if (wr_en === 1'b1 && wr_ready) begin
        if (obs_writes == 0) begin
          first_x = wr_x;
          first_y = wr_y;
        end
        last_x = wr_x;
        last_y = wr_y;
        obs_writes++;
      end
      if (!exp_en[k] || wr_ready) k++;
    end
    start = 1'b0;
    @(negedge clock);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("wr_en_at_done", wr_en, 0);
    check("write_count_vs_model", 64'(obs_writes), 64'(exp_writes));
    start = 1'b1;
    x = 10'(sx ^ 32'h2AA);
    @(negedge clock);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("start_in_done_ignored", busy, 0);
    check("idle_wr_en", wr_en, 0);
  endtask

  task automatic fill_pix(input int unsigned v);
    for (int p = 0; p < int'(NPIX); p++) pix[p] = v;
  endtask

  initial begin
    for (int i = 0; i < int'(NPAL); i++) pal[i] = 8'(i * 8'h11 + 8'h0F);
    fh = 1'b0;
    fv = 1'b0;

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_x", wr_x, 0);
    check("rst_wr_y", wr_y, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clock);

    // Solid sprite, full write stream
    fill_pix(1);
    pal[1] = 8'h5A;
    sx = 100; sy = 50;
    run_blit(0, -1, 1'b0);
    check("t1_writes", 64'(obs_writes), 256);
    check("t1_first", {first_x, first_y}, {10'd100, 10'd50});
    check("t1_last", {last_x, last_y}, {10'd115, 10'd65});

    // Checkerboard of transparent / index 3
    for (int r = 0; r < int'(SPR_H); r++)
      for (int c = 0; c < int'(SPR_W); c++)
        pix[r*SPR_W + c] = ((r + c) % 2 == 1) ? 3 : 0;
    pal[3] = 8'hE0;
    sx = 10; sy = 20;
    run_blit(0, -1, 1'b0);
    check("t2_writes", 64'(obs_writes), 128);

    // Bottom-right corner clipping
    fill_pix(1);
    sx = 632; sy = 472;
    run_blit(0, -1, 1'b0);
    check("t3_writes", 64'(obs_writes), 64);
    check("t3_last", {last_x, last_y}, {10'd639, 10'd479});

    // Three-cycle stall on pixel 5
    sx = 300; sy = 200;
    run_blit(2, -1, 1'b0);
    check("t4_writes", 64'(obs_writes), 256);

    // Reset at pixel 40, then a clean blit with a start pulse while busy
    sx = 0; sy = 0;
    run_blit(0, 40, 1'b0);
    sx = 7; sy = 9;
    run_blit(1, -1, 1'b1);
    check("t5_writes", 64'(obs_writes), 256);

`ifdef SPRITE_BLIT_FLIP_EN
    // Horizontal mirror of a single top-left pixel
    fill_pix(0);
    pix[0] = 1;
    fh = 1'b1;
    sx = 200; sy = 100;
    run_blit(0, -1, 1'b0);
    check("t6_writes", 64'(obs_writes), 1);
    check("t6_pos", {last_x, last_y}, {10'd215, 10'd100});
    fh = 1'b0;
`endif

    // Random scenes under random back-pressure
    for (int t = 0; t < 3; t++) begin
      for (int p = 0; p < int'(NPIX); p++) pix[p] = $urandom_range(0, NPAL - 1);
      for (int i = 0; i < int'(NPAL); i++) pal[i] = 8'($urandom);
      sx = $urandom_range(0, 1023);
      sy = $urandom_range(0, 1023);
      if (t == 0) begin
        sx = $urandom_range(600, 660);
        sy = $urandom_range(440, 500);
      end
`ifdef SPRITE_BLIT_FLIP_EN
      fh = 1'($urandom);
      fv = 1'($urandom);
`endif
      run_blit(1, -1, (t == 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
